// File: rtl/fsm_job_launcher_pkg.sv
// Package shared by the job launcher and sibling go/done FSMs.
// Holds the launcher state encoding.
package fsm_job_launcher_pkg;

  localparam int unsigned STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE   = 3'd0,
    S_CLEAR  = 3'd1,
    S_LAUNCH = 3'd2,
    S_WAIT   = 3'd3,
    S_DONE   = 3'd4,
    S_TOUT   = 3'd5
  } state_t;

endpackage

// File: rtl/fsm_job_launcher_if.sv
// Worker handshake bundle between a job launcher (master) and a go/done
// worker FSM (slave).
//   wrk_rst  : synchronous reset to the worker (master -> slave)
//   wrk_go   : one-cycle go pulse (master -> slave)
//   wrk_done : worker done level, held until worker reset (slave -> master)
interface fsm_job_launcher_if;
  logic wrk_rst;
  logic wrk_go;
  logic wrk_done;

  modport master (output wrk_rst, output wrk_go, input wrk_done);
  modport slave  (input wrk_rst, input wrk_go, output wrk_done);
endinterface

// File: rtl/fsm_job_launcher_wait_timer.sv
// fsm_wait_timer: small up-counter with synchronous clear and enable.
// expire is high while count equals limit; the caller chooses the limit
// per phase so one counter serves both the clear phase and the wait phase.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   clr      : clear count to zero (wins over en)
//   en       : increment count
//   limit    : compare value for expire
//   count    : current count
//   expire   : count == limit
module fsm_wait_timer #(
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [CNT_W-1:0] limit,
  output logic [CNT_W-1:0] count,
  output logic             expire
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + CNT_W'(1);
    end
  end

  assign expire = (count == limit);

endmodule

// File: rtl/fsm_job_launcher.sv
// fsm_job_launcher: initiator side of the go/done handshake.
// Each job resets the worker (wrk_rst for CLR_CYCLES cycles), pulses wrk_go,
// then waits for wrk_done with a timeout. A one-deep pending slot queues one
// start that arrives while busy; further starts are dropped and flagged.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   start        : request one job (sampled every cycle)
//   busy         : launcher not idle
//   wrk          : worker handshake (wrk_rst, wrk_go out; wrk_done in)
//   job_ok       : pulse, job finished with done
//   job_timeout  : pulse, job abandoned after TIMEOUT wait cycles
//   start_drop   : pulse, start lost (busy with pending already set)
//   job_count    : completed ok jobs, wrapping
//   wait_cycles  : done-low wait cycles of the last finished job
module fsm_job_launcher
  import fsm_job_launcher_pkg::*;
#(
  parameter  int unsigned TIMEOUT    = 32,
  parameter  int unsigned CLR_CYCLES = 2,
  parameter  int unsigned JOB_CNT_W  = 8,
  localparam int unsigned WAIT_W     = $clog2(TIMEOUT + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  fsm_job_launcher_if.master    wrk,
  output logic                  job_ok,
  output logic                  job_timeout,
  output logic                  start_drop,
  output logic [JOB_CNT_W-1:0]  job_count,
  output logic [WAIT_W-1:0]     wait_cycles
);

  state_t            state;
  state_t            next_state;
  logic              pending;
  logic              tmr_clr;
  logic              tmr_en;
  logic              tmr_expire;
  logic [WAIT_W-1:0] tmr_limit;
  logic [WAIT_W-1:0] tmr_count;

  // One counter times both phases: IDLE clears it so CLEAR counts
  // 0..CLR_CYCLES-1, LAUNCH clears it so WAIT starts from 0.
  fsm_wait_timer #(
    .CNT_W (WAIT_W)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clr    (tmr_clr),
    .en     (tmr_en),
    .limit  (tmr_limit),
    .count  (tmr_count),
    .expire (tmr_expire)
  );

  always_comb begin
    next_state = state;
    tmr_clr    = 1'b0;
    tmr_en     = 1'b0;
    tmr_limit  = WAIT_W'(TIMEOUT - 1);
    unique case (state)
      S_IDLE: begin
        tmr_clr = 1'b1;
        if (start || pending) begin
          next_state = S_CLEAR;
        end
      end
      S_CLEAR: begin
        tmr_limit = WAIT_W'(CLR_CYCLES - 1);
        tmr_en    = 1'b1;
        if (tmr_expire) begin
          next_state = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        tmr_clr    = 1'b1;
        next_state = S_WAIT;
      end
      S_WAIT: begin
        // done has priority over the timeout on the last wait cycle
        if (wrk.wrk_done) begin
          next_state = S_DONE;
        end else if (tmr_expire) begin
          next_state = S_TOUT;
        end else begin
          tmr_en = 1'b1;
        end
      end
      S_DONE, S_TOUT: begin
        tmr_clr    = 1'b1;
        next_state = S_IDLE;
      end
      default: begin
        next_state = S_IDLE;
      end
    endcase
  end

  // Outputs are registered from next_state so they line up with the state
  // register. wrk_rst is held high only while in reset and during CLEAR.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      pending     <= 1'b0;
      busy        <= 1'b0;
      wrk.wrk_rst <= 1'b1;
      wrk.wrk_go  <= 1'b0;
      job_ok      <= 1'b0;
      job_timeout <= 1'b0;
      start_drop  <= 1'b0;
      job_count   <= '0;
      wait_cycles <= '0;
    end else begin
      state       <= next_state;
      busy        <= (next_state != S_IDLE);
      wrk.wrk_rst <= (next_state == S_CLEAR);
      wrk.wrk_go  <= (next_state == S_LAUNCH);
      job_ok      <= (next_state == S_DONE);
      job_timeout <= (next_state == S_TOUT);
      start_drop  <= start && (state != S_IDLE) && pending;

      // In IDLE any pending request is consumed by the launch it triggers;
      // a start arriving together with it is absorbed into that launch.
      if (state == S_IDLE) begin
        pending <= 1'b0;
      end else if (start) begin
        pending <= 1'b1;
      end

      if (next_state == S_DONE) begin
        job_count   <= job_count + JOB_CNT_W'(1);
        wait_cycles <= tmr_count;
      end else if (next_state == S_TOUT) begin
        wait_cycles <= WAIT_W'(TIMEOUT);
      end
    end
  end

endmodule

// File: tb/tb_fsm_job_launcher.sv
module tb_fsm_job_launcher;

  localparam int TIMEOUT    = 32;
  localparam int CLR_CYCLES = 2;
  localparam int JOB_CNT_W  = 8;
  localparam int WAIT_W     = $clog2(TIMEOUT + 1);

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 start = 1'b0;
  logic                 busy;
  logic                 job_ok;
  logic                 job_timeout;
  logic                 start_drop;
  logic [JOB_CNT_W-1:0] job_count;
  logic [WAIT_W-1:0]    wait_cycles;

  fsm_job_launcher_if wrk_if ();

  fsm_job_launcher #(
    .TIMEOUT    (TIMEOUT),
    .CLR_CYCLES (CLR_CYCLES),
    .JOB_CNT_W  (JOB_CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .busy        (busy),
    .wrk         (wrk_if),
    .job_ok      (job_ok),
    .job_timeout (job_timeout),
    .start_drop  (start_drop),
    .job_count   (job_count),
    .wait_cycles (wait_cycles)
  );

  always #5 clk = ~clk;

  // Worker model: after go, done stays low for w_delay cycles, then rises
  // and is held until wrk_rst. Negative delay: done never rises.
  int   w_delay  = 0;
  int   w_left   = -1;
  logic w_done   = 1'b0;
  logic inj_done = 1'b0;
  assign wrk_if.wrk_done = w_done | inj_done;

  always @(posedge clk) begin
    if (wrk_if.wrk_rst) begin
      w_done <= 1'b0;
      w_left <= -1;
    end else if (wrk_if.wrk_go) begin
      w_done <= (w_delay == 0);
      w_left <= (w_delay > 0) ? w_delay - 1 : -1;
    end else if (w_left > 0) begin
      w_left <= w_left - 1;
    end else if (w_left == 0) begin
      w_done <= 1'b1;
      w_left <= -1;
    end
  end

  // Scoreboard
  typedef struct {
    bit          ok;
    int unsigned wcyc;
    int unsigned cnt;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int unsigned exp_count = 0;
  int          checks = 0;
  int          errors = 0;
  int          ok_pulses = 0;
  int          tout_pulses = 0;
  int          drop_pulses = 0;

  always @(negedge clk) begin
    if (!rst) begin
      if (job_ok || job_timeout) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_end got ok=%0b tout=%0b exp no job end", job_ok, job_timeout);
        end else begin
          mon_e = sb.pop_front();
          checks++;
          if ({job_ok, job_timeout} !== (mon_e.ok ? 2'b10 : 2'b01)) begin
            errors++;
            $display("FAIL end_kind got ok=%0b tout=%0b exp ok=%0b", job_ok, job_timeout, mon_e.ok);
          end
          checks++;
          if (wait_cycles !== WAIT_W'(mon_e.wcyc)) begin
            errors++;
            $display("FAIL wait_cycles got %0d exp %0d", wait_cycles, mon_e.wcyc);
          end
          checks++;
          if (job_count !== JOB_CNT_W'(mon_e.cnt)) begin
            errors++;
            $display("FAIL job_count got %0d exp %0d", job_count, mon_e.cnt);
          end
        end
      end
      if (job_ok)      ok_pulses++;
      if (job_timeout) tout_pulses++;
      if (start_drop)  drop_pulses++;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic push_job(input int d);
    exp_t e;
    if (d >= 0 && d < TIMEOUT) begin
      exp_count = (exp_count + 1) % (1 << JOB_CNT_W);
      e.ok   = 1'b1;
      e.wcyc = d;
    end else begin
      e.ok   = 1'b0;
      e.wcyc = TIMEOUT;
    end
    e.cnt = exp_count;
    sb.push_back(e);
  endtask

  task automatic wait_done(input string name, input int budget);
    int n;
    n = 0;
    while ((busy !== 1'b0 || sb.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= budget) begin
      errors++;
      $display("FAIL %s_idle got busy=%0b outstanding=%0d exp idle within %0d cycles",
               name, busy, sb.size(), budget);
    end
  endtask

  task automatic wait_go(input string name);
    int n;
    n = 0;
    while (wrk_if.wrk_go !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 20) begin
      errors++;
      $display("FAIL %s_go got no wrk_go exp wrk_go within 20 cycles", name);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(2);
    checks++;
    if (wrk_if.wrk_rst !== 1'b1) begin
      errors++;
      $display("FAIL reset_wrk_rst got %0b exp 1", wrk_if.wrk_rst);
    end
    checks++;
    if ({busy, wrk_if.wrk_go, job_ok, job_timeout, start_drop} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags got %05b exp 00000",
               {busy, wrk_if.wrk_go, job_ok, job_timeout, start_drop});
    end
    checks++;
    if (job_count !== '0 || wait_cycles !== '0) begin
      errors++;
      $display("FAIL reset_counts got count=%0d wait=%0d exp 0 0", job_count, wait_cycles);
    end
    rst = 1'b0;
    tick(3);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle_busy got %0b exp 0", busy);
    end
  endtask

  task automatic test_single();
    int   ok0;
    logic [3:0] rmask;
    logic [3:0] gmask;
    ok0 = ok_pulses;
    w_delay = 5;
    push_job(5);
    pulse_start();
    rmask = '0;
    gmask = '0;
    for (int i = 0; i < 4; i++) begin
      rmask[i] = wrk_if.wrk_rst;
      gmask[i] = wrk_if.wrk_go;
      @(negedge clk);
    end
    wait_done("single", 60);
    checks++;
    if (rmask !== 4'b0011) begin
      errors++;
      $display("FAIL single_wrk_rst got %04b exp 0011", rmask);
    end
    checks++;
    if (gmask !== 4'b0100) begin
      errors++;
      $display("FAIL single_wrk_go got %04b exp 0100", gmask);
    end
    checks++;
    if (ok_pulses !== ok0 + 1) begin
      errors++;
      $display("FAIL single_ok_pulses got %0d exp %0d", ok_pulses, ok0 + 1);
    end
    checks++;
    if (job_count !== JOB_CNT_W'(exp_count) || wait_cycles !== WAIT_W'(5)) begin
      errors++;
      $display("FAIL single_status got count=%0d wait=%0d exp count=%0d wait=5",
               job_count, wait_cycles, exp_count);
    end
  endtask

  task automatic test_timeout();
    int ok0;
    int t0;
    int lat;
    ok0 = ok_pulses;
    t0  = tout_pulses;
    w_delay = -1;
    push_job(-1);
    pulse_start();
    wait_go("timeout");
    lat = 0;
    while (job_timeout !== 1'b1 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (lat != TIMEOUT + 1) begin
      errors++;
      $display("FAIL timeout_latency got %0d exp %0d cycles from go", lat, TIMEOUT + 1);
    end
    wait_done("timeout", 60);
    checks++;
    if (tout_pulses !== t0 + 1 || ok_pulses !== ok0) begin
      errors++;
      $display("FAIL timeout_pulses got tout=%0d ok=%0d exp tout=%0d ok=%0d",
               tout_pulses, ok_pulses, t0 + 1, ok0);
    end
    checks++;
    if (wait_cycles !== WAIT_W'(TIMEOUT) || job_count !== JOB_CNT_W'(exp_count)) begin
      errors++;
      $display("FAIL timeout_status got wait=%0d count=%0d exp wait=%0d count=%0d",
               wait_cycles, job_count, TIMEOUT, exp_count);
    end
  endtask

  task automatic test_pending();
    int ok0;
    int d0;
    ok0 = ok_pulses;
    d0  = drop_pulses;
    w_delay = 10;
    push_job(10);
    push_job(10);
    pulse_start();
    wait_go("pending");
    tick(2);
    pulse_start();
    pulse_start();
    wait_done("pending", 120);
    checks++;
    if (drop_pulses !== d0 + 1) begin
      errors++;
      $display("FAIL pending_drop got %0d exp %0d", drop_pulses, d0 + 1);
    end
    checks++;
    if (ok_pulses !== ok0 + 2) begin
      errors++;
      $display("FAIL pending_ok_pulses got %0d exp %0d", ok_pulses, ok0 + 2);
    end
    checks++;
    if (job_count !== JOB_CNT_W'(exp_count)) begin
      errors++;
      $display("FAIL pending_count got %0d exp %0d", job_count, exp_count);
    end
  endtask

  task automatic test_boundary();
    int delays[3] = '{TIMEOUT - 1, 0, TIMEOUT};
    int ok0;
    int t0;
    ok0 = ok_pulses;
    t0  = tout_pulses;
    foreach (delays[i]) begin
      w_delay = delays[i];
      push_job(delays[i]);
      pulse_start();
      wait_done("boundary", 80);
    end
    checks++;
    if (ok_pulses !== ok0 + 2 || tout_pulses !== t0 + 1) begin
      errors++;
      $display("FAIL boundary_pulses got ok=%0d tout=%0d exp ok=%0d tout=%0d",
               ok_pulses, tout_pulses, ok0 + 2, t0 + 1);
    end
  endtask

  // Each launch starts with the previous job's done still high.
  task automatic test_back_to_back();
    int delays[4] = '{3, 1, 7, 2};
    int ok0;
    ok0 = ok_pulses;
    foreach (delays[i]) begin
      w_delay = delays[i];
      push_job(delays[i]);
      pulse_start();
      wait_done("b2b", 60);
    end
    checks++;
    if (ok_pulses !== ok0 + 4) begin
      errors++;
      $display("FAIL b2b_ok_pulses got %0d exp %0d", ok_pulses, ok0 + 4);
    end
  endtask

  // done forced high through CLEAR and LAUNCH must be ignored.
  task automatic test_stale_done();
    int ok0;
    ok0 = ok_pulses;
    w_delay  = 4;
    inj_done = 1'b1;
    push_job(4);
    pulse_start();
    wait_go("stale");
    inj_done = 1'b0;
    wait_done("stale", 60);
    checks++;
    if (ok_pulses !== ok0 + 1 || wait_cycles !== WAIT_W'(4)) begin
      errors++;
      $display("FAIL stale_done got ok=%0d wait=%0d exp ok=%0d wait=4",
               ok_pulses, wait_cycles, ok0 + 1);
    end
  endtask

  task automatic test_async_reset();
    int busy_seen;
    w_delay = -1;
    push_job(-1);
    pulse_start();
    wait_go("areset");
    tick(3);
    pulse_start();
    tick(2);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (wrk_if.wrk_rst !== 1'b1) begin
      errors++;
      $display("FAIL areset_wrk_rst got %0b exp 1", wrk_if.wrk_rst);
    end
    checks++;
    if ({busy, wrk_if.wrk_go, job_ok, job_timeout, start_drop} !== 5'b0) begin
      errors++;
      $display("FAIL areset_flags got %05b exp 00000",
               {busy, wrk_if.wrk_go, job_ok, job_timeout, start_drop});
    end
    checks++;
    if (job_count !== '0 || wait_cycles !== '0) begin
      errors++;
      $display("FAIL areset_counts got count=%0d wait=%0d exp 0 0", job_count, wait_cycles);
    end
    sb.delete();
    exp_count = 0;
    tick(2);
    rst = 1'b0;
    busy_seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (busy) busy_seen++;
    end
    checks++;
    if (busy_seen != 0) begin
      errors++;
      $display("FAIL areset_pending_lost got %0d busy cycles exp 0", busy_seen);
    end
  endtask

  task automatic test_wrap();
    int ok0;
    ok0 = ok_pulses;
    w_delay = 1;
    for (int i = 0; i < (1 << JOB_CNT_W); i++) begin
      push_job(1);
      pulse_start();
      wait_done("wrap", 40);
    end
    checks++;
    if (ok_pulses !== ok0 + (1 << JOB_CNT_W)) begin
      errors++;
      $display("FAIL wrap_ok_pulses got %0d exp %0d", ok_pulses, ok0 + (1 << JOB_CNT_W));
    end
    checks++;
    if (job_count !== '0) begin
      errors++;
      $display("FAIL wrap_count got %0d exp 0", job_count);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_timeout();
    test_pending();
    test_boundary();
    test_back_to_back();
    test_stale_done();
    test_async_reset();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got no completion exp finish before 1ms");
    $fatal(1, "watchdog expired");
  end

endmodule
